// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - byte/transmit handshake between the SPI slave block and the register controller
interface spi_reg_ctrl_if;
    logic       spi_ssig;
    logic [7:0] spi_data;
    logic       spi_ce0;
    logic [7:0] tx_data;
    logic       tx_load;

    // SPI byte receiver side: delivers received bytes and chip enable, takes MISO bytes
    modport master (
        output spi_ssig,
        output spi_data,
        output spi_ce0,
        input  tx_data,
        input  tx_load
    );

    // Register controller side
    modport slave (
        input  spi_ssig,
        input  spi_data,
        input  spi_ce0,
        output tx_data,
        output tx_load
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command sequencer driving a small burst-addressed register file
module spi_reg_ctrl #(
    parameter int         NUM_REGS = 4,
    parameter int         ADDR_W   = 2,
    parameter logic [7:0] OOR_READ = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_reg_ctrl_if.slave         spi,
    input  logic                  err_clr,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic [3:0]            led,
    output logic                  busy,
    output logic                  frame_err
);

    localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } state_t;

    state_t            state;
    logic [7:0]        regs [NUM_REGS];
    logic [ADDR_W-1:0] addr;
    logic              oor;

    logic              ssig_s1;
    logic              ssig_s2;
    logic              ssig_d;
    logic              ce_s1;
    logic              ce_s2;
    logic              cs_prev;

    logic              byte_stb;
    logic              cs_act;
    logic              cs_rise;
    logic              cs_fall;
    logic              cmd_oor;
    logic              set_err;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] addr_inc;

    // Two-flop synchronisers for the sclk-domain strobe and the raw chip enable,
    // plus one extra stage of each for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssig_s1 <= 1'b0;
            ssig_s2 <= 1'b0;
            ssig_d  <= 1'b0;
            ce_s1   <= 1'b1;
            ce_s2   <= 1'b1;
            cs_prev <= 1'b0;
        end else begin
            ssig_s1 <= spi.spi_ssig;
            ssig_s2 <= ssig_s1;
            ssig_d  <= ssig_s2;
            ce_s1   <= spi.spi_ce0;
            ce_s2   <= ce_s1;
            cs_prev <= ~ce_s2;
        end
    end

    assign byte_stb = ssig_s2 & ~ssig_d;
    assign cs_act   = ~ce_s2;
    assign cs_rise  = cs_act & ~cs_prev;
    assign cs_fall  = ~cs_act & cs_prev;

    // Command byte decode: low bits select the start register, bits[6:0] decide range.
    assign cmd_addr = spi.spi_data[ADDR_W-1:0];
    assign cmd_oor  = ({1'b0, spi.spi_data[6:0]} >= NUM_REGS_B);
    assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

    // Error sources: a byte arriving with no frame open, or an out-of-range command.
    always_comb begin
        set_err = 1'b0;
        if (byte_stb) begin
            if (state == IDLE)
                set_err = 1'b1;
            else if (state == CMD && cmd_oor)
                set_err = 1'b1;
        end
    end

    // Frame sequencer: command decode, burst write/read, transmit loading and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            oor         <= 1'b0;
            spi.tx_data <= 8'h00;
            spi.tx_load <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 8'h00;
        end else begin
            spi.tx_load <= 1'b0;

            if (set_err)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_rise) begin
                        state <= CMD;
                        addr  <= '0;
                        oor   <= 1'b0;
                    end
                end
                CMD: begin
                    if (byte_stb) begin
                        addr <= cmd_addr;
                        oor  <= cmd_oor;
                        if (spi.spi_data[7]) begin
                            state <= WR;
                        end else begin
                            spi.tx_data <= cmd_oor ? OOR_READ : regs[cmd_addr];
                            spi.tx_load <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                WR: begin
                    if (byte_stb) begin
                        if (!oor)
                            regs[addr] <= spi.spi_data;
                        addr <= addr_inc;
                    end
                end
                RD: begin
                    if (byte_stb) begin
                        addr        <= addr_inc;
                        spi.tx_data <= oor ? OOR_READ : regs[addr_inc];
                        spi.tx_load <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Chip enable release ends the frame; a byte landing in the same cycle
            // has already been handled above.
            if (cs_fall)
                state <= IDLE;
        end
    end

    // Flattened register view and LED drive
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[8*g +: 8] = regs[g];
    end

    assign led  = regs[0][3:0];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - scoreboard bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

    logic        clk;
    logic        rst;
    logic        err_clr;
    logic [31:0] reg_out;
    logic [3:0]  led;
    logic        busy;
    logic        frame_err;

    spi_reg_ctrl_if bus ();

    spi_reg_ctrl #(
        .NUM_REGS (4),
        .ADDR_W   (2),
        .OOR_READ (8'hEE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (bus),
        .err_clr   (err_clr),
        .reg_out   (reg_out),
        .led       (led),
        .busy      (busy),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc;
    int         vectors;
    int         miscompares;
    logic [7:0] mdl [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdl_flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    // Every tx_load is matched against the oldest expected read byte and its due cycle.
    always @(posedge clk) begin
        #1;
        if (!rst && bus.tx_load) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tx_load_unexpected: got tx_data=%h at cycle %0d, required no load", bus.tx_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.tx_data !== mon_e.data || cyc != mon_e.cyc) begin
                    miscompares++;
                    $display("FAIL tx_read: got data=%h cycle=%0d, required data=%h cycle=%0d",
                             bus.tx_data, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    // A byte is acted on at the third rising edge after spi_ssig rises (two sync
    // flops plus edge detect); a read's tx_load is visible right after that edge.
    task automatic send_byte(input logic [7:0] b, input bit exp_load, input logic [7:0] exp_data,
                             input bit drop_ce);
        exp_t e;
        @(negedge clk);
        bus.spi_data = b;
        bus.spi_ssig = 1'b1;
        if (drop_ce)
            bus.spi_ce0 = 1'b1;
        if (exp_load) begin
            e.data = exp_data;
            e.cyc  = cyc + 3;
            exp_q.push_back(e);
        end
        repeat (3) @(negedge clk);
        bus.spi_ssig = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_on();
        @(negedge clk);
        bus.spi_ce0 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_off();
        @(negedge clk);
        bus.spi_ce0 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d reads outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_regs(input string name);
        vectors++;
        if (reg_out !== mdl_flat()) begin
            miscompares++;
            $display("FAIL %s_regs: got %h, required %h", name, reg_out, mdl_flat());
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (reg_out !== 32'h0 || led !== 4'h0 || busy !== 1'b0 || frame_err !== 1'b0 ||
            bus.tx_load !== 1'b0 || bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got regs=%h led=%b busy=%b err=%b load=%b tx=%h, required all 0",
                     reg_out, led, busy, frame_err, bus.tx_load, bus.tx_data);
        end
    endtask

    task automatic test_single_write();
        cs_on();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_in_frame: got %b, required 1", busy);
        end
        send_byte(8'h80, 0, 8'h00, 0);
        send_byte(8'h0A, 0, 8'h00, 0);
        cs_off();
        mdl[0] = 8'h0A;
        check_regs("single");
        vectors++;
        if (led !== 4'b1010 || busy !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_outputs: got led=%b busy=%b err=%b, required led=1010 busy=0 err=0",
                     led, busy, frame_err);
        end
    endtask

    task automatic test_burst_write();
        logic [7:0] data [3];
        int a;
        data = '{8'h11, 8'h22, 8'h33};
        cs_on();
        send_byte(8'h82, 0, 8'h00, 0);
        a = 2;
        for (int i = 0; i < 3; i++) begin
            send_byte(data[i], 0, 8'h00, 0);
            mdl[a] = data[i];
            a = (a + 1) % 4;
        end
        cs_off();
        check_regs("burst_write");
        vectors++;
        if (reg_out[7:0] !== 8'h33 || reg_out[15:8] !== 8'h00) begin
            miscompares++;
            $display("FAIL burst_wrap: got reg0=%h reg1=%h, required reg0=33 reg1=00",
                     reg_out[7:0], reg_out[15:8]);
        end
    endtask

    task automatic test_burst_read();
        cs_on();
        send_byte(8'h81, 0, 8'h00, 0);
        send_byte(8'h44, 0, 8'h00, 0);
        cs_off();
        mdl[1] = 8'h44;
        check_regs("preload");
        cs_on();
        send_byte(8'h01, 1, mdl[1], 0);
        send_byte(8'h00, 1, mdl[2], 0);
        send_byte(8'h00, 1, mdl[3], 0);
        cs_off();
        wait_drain("burst_read");
    endtask

    task automatic test_read_wrap();
        cs_on();
        send_byte(8'h03, 1, mdl[3], 0);
        send_byte(8'hA5, 1, mdl[0], 0);
        send_byte(8'h5A, 1, mdl[1], 0);
        cs_off();
        wait_drain("read_wrap");
        check_regs("read_no_side_effect");
    endtask

    task automatic test_out_of_range();
        cs_on();
        send_byte(8'h85, 0, 8'h00, 0);
        send_byte(8'h55, 0, 8'h00, 0);
        cs_off();
        check_regs("oor_write");
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_err_set: got %b, required 1", frame_err);
        end
        cs_on();
        send_byte(8'h7F, 1, 8'hEE, 0);
        send_byte(8'h00, 1, 8'hEE, 0);
        cs_off();
        wait_drain("oor_read");
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_err_clr: got %b, required 0", frame_err);
        end
    endtask

    task automatic test_back_to_back();
        cs_on();
        send_byte(8'h81, 0, 8'h00, 0);
        // Final byte: CE0 released on the same edge spi_ssig rises, so the
        // synchronised strobe and chip-enable fall coincide.
        @(negedge clk);
        bus.spi_data = 8'h5A;
        bus.spi_ssig = 1'b1;
        bus.spi_ce0  = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_busy_before: got %b, required 1", busy);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || reg_out[15:8] !== 8'h5A) begin
            miscompares++;
            $display("FAIL b2b_landed: got busy=%b reg1=%h, required busy=0 reg1=5a", busy, reg_out[15:8]);
        end
        bus.spi_ssig = 1'b0;
        repeat (4) @(negedge clk);
        mdl[1] = 8'h5A;
        check_regs("b2b");
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_err: got %b, required 0", frame_err);
        end
    endtask

    task automatic test_idle_strobe();
        send_byte(8'h81, 0, 8'h00, 0);
        vectors++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_strobe: got err=%b busy=%b, required err=1 busy=0", frame_err, busy);
        end
        check_regs("idle_strobe");
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_midburst();
        cs_on();
        send_byte(8'h80, 0, 8'h00, 0);
        send_byte(8'h12, 0, 8'h00, 0);
        @(negedge clk);
        bus.spi_data = 8'h34;
        bus.spi_ssig = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (reg_out !== 32'h0 || led !== 4'h0 || busy !== 1'b0 || frame_err !== 1'b0 ||
            bus.tx_load !== 1'b0 || bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: got regs=%h led=%b busy=%b err=%b load=%b tx=%h, required all 0",
                     reg_out, led, busy, frame_err, bus.tx_load, bus.tx_data);
        end
        bus.spi_ssig = 1'b0;
        bus.spi_ce0  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++)
            mdl[i] = 8'h00;
        check_regs("after_reset");
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        rst          = 1'b1;
        err_clr      = 1'b0;
        bus.spi_ssig = 1'b0;
        bus.spi_data = 8'h00;
        bus.spi_ce0  = 1'b1;
        for (int i = 0; i < 4; i++)
            mdl[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_single_write();
        test_burst_write();
        test_burst_read();
        test_read_wrap();
        test_out_of_range();
        test_back_to_back();
        test_idle_strobe();
        test_reset_midburst();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command sequencer behind the SPI slave byte receiver on the icestick top level.
- Synchronises the SPI byte strobe and chip-enable into the system clock domain.
- Decodes a per-frame command byte and sequences burst writes and reads into a small register file.
- Drives the LEDs from register 0 and presents transmit bytes plus a load strobe back to the SPI block for MISO.

Parameters:
- NUM_REGS, 4, number of 8-bit registers; 2..128.
- ADDR_W, 2, address width; must equal clog2(NUM_REGS).
- OOR_READ, 8'hEE, byte returned for out-of-range reads.

Ports:
- clk  in  1  system clock (12 MHz on icestick).
- rst  in  1  asynchronous, active-high reset.
- spi_ssig  in  1  byte-complete flag from SPI block, sclk domain; high ≥2 clk periods per byte.
- spi_data  in  8  received byte; stable while spi_ssig high.
- spi_ce0  in  1  raw chip enable, active low, async.
- err_clr  in  1  synchronous clear of frame_err.
- tx_data  out  8  next byte for the SPI block to shift out on MISO.
- tx_load  out  1  one-cycle pulse: tx_data valid, SPI block latches it.
- reg_out  out  NUM_REGS*8  flattened register file; reg n at bits [8n+7:8n].
- led  out  4  reg0[3:0].
- busy  out  1  high while a frame is active (state != IDLE).
- frame_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert): all outputs 0; registers 0; FSM IDLE; addr 0; synchroniser flops: ssig 0, ce0 1.
- Synchronisers: 2 flops each on spi_ssig and spi_ce0.
  - byte_stb = rising edge of synced ssig: 3 clk after spi_ssig rises.
  - cs_act = synced ce0 low.
  - spi_data sampled in the byte_stb cycle.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE -> CMD when cs_act rises.
  - Any state -> IDLE when cs_act falls.
- CMD, on byte_stb:
  - Byte bit7 = 1 (write): addr <= bits[ADDR_W-1:0] -> WR.
  - Byte bit7 = 0 (read): addr <= bits[ADDR_W-1:0]; next cycle tx_data <= reg[addr] with tx_load pulse -> RD.
  - Address range check uses bits[6:0] against NUM_REGS.
- WR, on byte_stb: reg[addr] <= byte; addr <= addr+1, wrapping NUM_REGS-1 -> 0. Burst length unlimited.
- RD, on byte_stb: received byte ignored; addr <= addr+1 (wrap); next cycle tx_data <= reg[new addr] with tx_load pulse.
- Read latency: tx_load asserts exactly 1 clk after the triggering byte_stb.
- Out-of-range command (bits[6:0] >= NUM_REGS):
  - frame_err set.
  - Writes in that frame dropped.
  - Reads return OOR_READ for the whole frame.
- byte_stb while IDLE (cs inactive): byte discarded, frame_err set.
- Simultaneous byte_stb and cs_act falling in the same cycle: byte processed fully (write lands / tx_load issued), then IDLE.
- CE0 deasserts mid-byte: no strobe arrives; partial byte lost silently; IDLE; no error.
- New frame: always re-enters CMD; addr not carried across frames.
- frame_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- tx_data holds its last value between loads; tx_load never asserts outside RD/CMD->RD transitions.
- rst asserted mid-frame: immediate return to reset values; registers cleared.

Test Plan:
- Reset then frame {0x80, 0x0A}: reg0 = 0x0A, led = 4'b1010, busy high during frame, 0 after CE0 high, frame_err 0.
- Burst write {0x82, 0x11, 0x22, 0x33}: reg2 = 0x11, reg3 = 0x22, reg0 = 0x33 (wrap), reg1 unchanged.
- After preload, read frame {0x01, 0x00, 0x00}: three tx_load pulses, each 1 clk after byte_stb, carrying reg1, reg2, reg3.
- Out-of-range frame {0x85, 0x55}: no register change, frame_err = 1.
  - Then read {0x7F, 0x00}: tx_data = 0xEE twice.
  - err_clr pulse: frame_err = 0.
- CE0 high in the same cycle as the last byte_stb of {0x81, 0x5A}: reg1 = 0x5A, FSM IDLE next cycle.
- spi_ssig pulse with CE0 high: frame_err = 1, no writes.
- rst asserted mid-burst: all registers and outputs 0 within the same cycle (async).
